move_sequencer: RTL and testbench
=================================

# move_sequencer

Turn controller that sits between the debounced button/tick front end and the `GameState` datapath of the ultimate tic-tac-toe design. It runs cursor navigation over the 9 boards and 9 tiles, and enforces the "next board = last tile played" rule using the live `X_state`/`O_state` vectors. It tracks whose turn it is and issues single-cycle `move` commits. A per-turn countdown auto-plays a legal move on expiry.

## Interface
- `TURN_SECONDS`, default 30: countdown reload value in `tick` units (1..99).
- `AUTO_MOVE`, default 1: 1 = auto-commit on expiry; 0 = saturate at 0 and raise `timeout`.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: asynchronous, active-high reset.
- `tick` in 1: one-cycle pulse per second.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_sel` in 1 each: one-cycle debounced pulses.
- `X_state`, `O_state` in 81: occupancy from `GameState`; bit index = board*9 + tile.
- `move` out 1: one-cycle commit strobe to `GameState`.
- `currBoard`, `currTile` out 4 each: committed coordinates; registered, held until the next commit.
- `cursor_board`, `cursor_tile` out 4 each: highlight for display.
- `phase` out 1: 0 = choosing board, 1 = choosing tile.
- `player` out 1: 0 = O, 1 = X; mirrors `GameState`.
- `time_left` out 7: remaining seconds.
- `timeout` out 1: level signal, set only when `AUTO_MOVE` = 0.
- `illegal` out 1: one-cycle pulse on a rejected selection.

## Operation
- Board b is **closed** when the 9 bits `(X_state | O_state)[b*9 +: 9]` are all ones; otherwise it is **open**. Tile t of board b is **free** when its bit is 0 in both vectors.
- State machine:
  - **S_BOARD**
    - Directions move `cursor_board` over the 3x3 grid with wrap-around (row/col mod 3; tile = 3*row + col).
    - `btn_sel` on an open board → S_TILE, with `cursor_tile` = 4.
    - `btn_sel` on a closed board → `illegal` pulse, stay.
  - **S_TILE**
    - Directions move `cursor_tile`; the board stays locked.
    - `btn_sel` on a free tile → latch `currBoard`/`currTile` → S_COMMIT.
    - `btn_sel` on an occupied tile → `illegal` pulse.
  - **S_COMMIT**: `move` = 1 for exactly this cycle → S_SETTLE.
  - **S_SETTLE**: evaluate the result one cycle later (after `GameState` has registered the move).
    - Both vectors all-zero (game won or reset): set `player` = 0, go to S_BOARD with the cursor at 4.
    - Committed bit set, or committed board cleared in both vectors (sub-board draw): the move is accepted. Toggle `player`, reload the timer. If board `currTile` is open, go to S_TILE with `cursor_board` = `currTile` and `cursor_tile` = 4; else go to S_BOARD.
    - Otherwise the move is rejected: pulse `illegal`, return to S_TILE with the same player.
- Button priority within one cycle: sel > up > down > left > right. All buttons are ignored in S_COMMIT and S_SETTLE.
- Timer:
  - Decrements on `tick` in S_BOARD and S_TILE only.
  - At 0 with `AUTO_MOVE` = 1: pick the lowest-index free tile. In S_TILE this comes from the active board. In S_BOARD it comes from the lowest-index open board. Latch it and go to S_COMMIT.
  - At 0 with `AUTO_MOVE` = 0: hold 0, set `timeout`; it clears on the next accepted move.
- If `btn_sel` and expiry occur in the same cycle, a legal `btn_sel` wins; an illegal one pulses `illegal` and the auto-move proceeds.

## Timing
- Reset values:
  - S_BOARD, `phase` = 0, `player` = 0.
  - `cursor_board` = `cursor_tile` = 4; `currBoard` = `currTile` = 0.
  - `move` = `illegal` = `timeout` = 0; `time_left` = `TURN_SECONDS`.
- Latency from a legal `btn_sel` to `move` high: 1 cycle. The next turn is accepted 2 cycles after `move` rises.
- `currBoard`/`currTile` are stable from the `move` cycle through S_SETTLE.
- All outputs are registered; no combinational path from inputs to `move`.
- `rst` mid-commit kills `move` immediately. `GameState` shares `rst`, so the two blocks stay consistent.

## Structure
- Shared package `ttt_pkg`:
  - state enum (S_BOARD, S_TILE, S_COMMIT, S_SETTLE);
  - constants NUM_BOARDS = 9, NUM_TILES = 9, CENTER = 4;
  - function `board_open`;
  - function `first_free` (9-bit priority encoder);
  - wrap-around navigation function.
- One sub-module, `turn_timer`: reload, tick decrement, saturate-at-0, expiry pulse.

## Test plan
- Reset, then `btn_sel`, `btn_sel` → `move` pulse with `currBoard` = 4, `currTile` = 4. Afterwards `player` = 1, `phase` = 1, `cursor_board` = 4.
- Play a tile so that the next board is closed (all 9 bits set) → S_BOARD (`phase` = 0). Select that closed board → `illegal` pulse, no `move`.
- `btn_sel` on an occupied tile → `illegal` = 1 for one cycle; state, `player` and `time_left` unchanged.
- From tile 2, press `btn_right` → `cursor_tile` = 0. From tile 0, press `btn_up` → `cursor_tile` = 6.
- `AUTO_MOVE` = 1, `TURN_SECONDS` = 3, 3 ticks in S_TILE on a board with tiles 0-1 occupied → `move` with `currTile` = 2. `time_left` reloads to 3 after acceptance.
- Force `X_state` = `O_state` = 0 in S_SETTLE (game won) → `player` = 0, `phase` = 0, `cursor_board` = 4.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types, constants and board/tile helpers for the ultimate tic-tac-toe turn logic.
package ttt_pkg;

  localparam int NUM_BOARDS = 9;
  localparam int NUM_TILES  = 9;
  localparam int OCC_W      = NUM_BOARDS * NUM_TILES;
  localparam logic [3:0] CENTER = 4'd4;

  typedef enum logic [1:0] {
    S_BOARD  = 2'd0,
    S_TILE   = 2'd1,
    S_COMMIT = 2'd2,
    S_SETTLE = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } nav_dir_e;

  // The 9 occupancy bits of one board; bit t is tile t.
  function automatic logic [8:0] board_bits(input logic [OCC_W-1:0] occ, input logic [3:0] b);
    return occ[int'(b)*NUM_TILES +: NUM_TILES];
  endfunction

  // A board is open while at least one of its tiles is free.
  function automatic logic board_open(input logic [OCC_W-1:0] occ, input logic [3:0] b);
    return ~(&board_bits(occ, b));
  endfunction

  // Lowest-index zero bit; returns 0 when every bit is set (callers check openness first).
  function automatic logic [3:0] first_free(input logic [8:0] bits);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_TILES - 1; i >= 0; i--) begin
      if (!bits[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Lowest-index open board; returns 0 when none is open (that board is then closed).
  function automatic logic [3:0] first_open_board(input logic [OCC_W-1:0] occ);
    logic [3:0] idx;
    idx = 4'd0;
    for (int b = NUM_BOARDS - 1; b >= 0; b--) begin
      if (board_open(occ, 4'(b))) idx = 4'(b);
    end
    return idx;
  endfunction

  // Step a 3x3 position (3*row + col) one cell in a direction, wrapping rows and columns.
  function automatic logic [3:0] nav_wrap(input logic [3:0] pos, input nav_dir_e dir);
    logic [3:0] row;
    logic [3:0] col;
    if (pos >= 4'd6)      row = 4'd2;
    else if (pos >= 4'd3) row = 4'd1;
    else                  row = 4'd0;
    col = pos - 4'd3 * row;
    case (dir)
      DIR_UP:   row = (row == 4'd0) ? 4'd2 : row - 4'd1;
      DIR_DOWN: row = (row == 4'd2) ? 4'd0 : row + 4'd1;
      DIR_LEFT: col = (col == 4'd0) ? 4'd2 : col - 4'd1;
      default:  col = (col == 4'd2) ? 4'd0 : col + 4'd1;
    endcase
    return 4'd3 * row + col;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn countdown: reload, decrement on tick while running, hold at zero, pulse on reaching zero.
module turn_timer #(
  parameter int unsigned TURN_SECONDS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reload_i,
  input  logic       tick_i,
  input  logic       run_i,
  output logic [6:0] count_o,
  output logic       zero_o,
  output logic       expired_o
);

  localparam logic [6:0] RELOAD = 7'(TURN_SECONDS);

  logic [6:0] count_q, count_d;
  logic       expired_q, expired_d;

  // Reload has priority over a tick; the count never goes below zero.
  always_comb begin
    count_d   = count_q;
    expired_d = 1'b0;
    if (reload_i) begin
      count_d = RELOAD;
    end else if (run_i && tick_i && (count_q != 7'd0)) begin
      count_d   = count_q - 7'd1;
      expired_d = (count_q == 7'd1);
    end
  end

  // Count and expiry pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= RELOAD;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign count_o   = count_q;
  assign zero_o    = (count_q == 7'd0);
  assign expired_o = expired_q;

endmodule

// File: rtl/move_sequencer.sv
// Turn controller: cursor navigation, next-board rule, move commit/settle and timed auto-play.
//
// state    | meaning
// S_BOARD  | choosing a board with the cursor
// S_TILE   | board locked, choosing a tile
// S_COMMIT | move strobe to GameState this cycle
// S_SETTLE | GameState has registered the move; judge the result
module move_sequencer
  import ttt_pkg::*;
#(
  parameter int unsigned TURN_SECONDS = 30,
  parameter int unsigned AUTO_MOVE    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_sel,
  input  logic [OCC_W-1:0] X_state,
  input  logic [OCC_W-1:0] O_state,
  output logic             move,
  output logic [3:0]       currBoard,
  output logic [3:0]       currTile,
  output logic [3:0]       cursor_board,
  output logic [3:0]       cursor_tile,
  output logic             phase,
  output logic             player,
  output logic [6:0]       time_left,
  output logic             timeout,
  output logic             illegal
);

  seq_state_e state_q, state_d;
  logic [3:0] curr_board_q, curr_board_d;
  logic [3:0] curr_tile_q, curr_tile_d;
  logic [3:0] cursor_board_q, cursor_board_d;
  logic [3:0] cursor_tile_q, cursor_tile_d;
  logic       player_q, player_d;
  logic       timeout_q, timeout_d;
  logic       illegal_q, illegal_d;

  logic             reload;
  logic             timer_zero;
  logic             timer_expired;
  logic [6:0]       timer_count;
  logic             run;
  logic [OCC_W-1:0] occ;
  logic [8:0]       cur_bits;
  logic [8:0]       commit_bits;
  logic [8:0]       auto_bits;
  logic [3:0]       auto_board;
  logic             auto_valid;
  logic             dir_valid;
  nav_dir_e         dir;
  logic             sel_legal;

  assign occ         = X_state | O_state;
  assign run         = (state_q == S_BOARD) || (state_q == S_TILE);
  assign cur_bits    = board_bits(occ, cursor_board_q);
  assign commit_bits = board_bits(occ, curr_board_q);
  // In S_TILE the auto-move stays on the locked board; in S_BOARD it takes the first open one.
  assign auto_board  = (state_q == S_TILE) ? cursor_board_q : first_open_board(occ);
  assign auto_bits   = board_bits(occ, auto_board);
  assign auto_valid  = ~(&auto_bits);
  assign dir_valid   = btn_up | btn_down | btn_left | btn_right;
  assign dir         = btn_up   ? DIR_UP   :
                       btn_down ? DIR_DOWN :
                       btn_left ? DIR_LEFT : DIR_RIGHT;

  turn_timer #(
    .TURN_SECONDS(TURN_SECONDS)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .reload_i (reload),
    .tick_i   (tick),
    .run_i    (run),
    .count_o  (timer_count),
    .zero_o   (timer_zero),
    .expired_o(timer_expired)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_BOARD;
      curr_board_q   <= 4'd0;
      curr_tile_q    <= 4'd0;
      cursor_board_q <= CENTER;
      cursor_tile_q  <= CENTER;
      player_q       <= 1'b0;
      timeout_q      <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      curr_board_q   <= curr_board_d;
      curr_tile_q    <= curr_tile_d;
      cursor_board_q <= cursor_board_d;
      cursor_tile_q  <= cursor_tile_d;
      player_q       <= player_d;
      timeout_q      <= timeout_d;
      illegal_q      <= illegal_d;
    end
  end

  // Next-state: buttons (sel > up > down > left > right), timed auto-move, settle judgement.
  always_comb begin
    state_d        = state_q;
    curr_board_d   = curr_board_q;
    curr_tile_d    = curr_tile_q;
    cursor_board_d = cursor_board_q;
    cursor_tile_d  = cursor_tile_q;
    player_d       = player_q;
    illegal_d      = 1'b0;
    reload         = 1'b0;
    sel_legal      = 1'b0;
    timeout_d      = timeout_q | ((AUTO_MOVE == 0) && timer_expired);

    case (state_q)
      S_BOARD, S_TILE: begin
        if (btn_sel) begin
          if (state_q == S_BOARD) begin
            if (board_open(occ, cursor_board_q)) begin
              state_d       = S_TILE;
              cursor_tile_d = CENTER;
              sel_legal     = 1'b1;
            end else begin
              illegal_d = 1'b1;
            end
          end else if (!cur_bits[cursor_tile_q]) begin
            state_d      = S_COMMIT;
            curr_board_d = cursor_board_q;
            curr_tile_d  = cursor_tile_q;
            sel_legal    = 1'b1;
          end else begin
            illegal_d = 1'b1;
          end
        end else if (dir_valid) begin
          if (state_q == S_BOARD) cursor_board_d = nav_wrap(cursor_board_q, dir);
          else                    cursor_tile_d  = nav_wrap(cursor_tile_q, dir);
        end

        // Expiry overrides navigation but never a legal selection made in the same cycle.
        if ((AUTO_MOVE != 0) && timer_zero && !sel_legal && auto_valid) begin
          state_d        = S_COMMIT;
          curr_board_d   = auto_board;
          curr_tile_d    = first_free(auto_bits);
          cursor_board_d = cursor_board_q;
          cursor_tile_d  = cursor_tile_q;
        end
      end

      S_COMMIT: begin
        state_d = S_SETTLE;
      end

      default: begin
        if ((X_state == '0) && (O_state == '0)) begin
          state_d        = S_BOARD;
          player_d       = 1'b0;
          cursor_board_d = CENTER;
          cursor_tile_d  = CENTER;
          reload         = 1'b1;
          timeout_d      = 1'b0;
        end else if (commit_bits[curr_tile_q] || (commit_bits == 9'd0)) begin
          player_d      = ~player_q;
          reload        = 1'b1;
          timeout_d     = 1'b0;
          cursor_tile_d = CENTER;
          if (board_open(occ, curr_tile_q)) begin
            state_d        = S_TILE;
            cursor_board_d = curr_tile_q;
          end else begin
            state_d = S_BOARD;
          end
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TILE;
        end
      end
    endcase
  end

  // Outputs come straight from registers; move and phase are decodes of the state register.
  always_comb begin
    move         = (state_q == S_COMMIT);
    phase        = (state_q != S_BOARD);
    currBoard    = curr_board_q;
    currTile     = curr_tile_q;
    cursor_board = cursor_board_q;
    cursor_tile  = cursor_tile_q;
    player       = player_q;
    time_left    = timer_count;
    timeout      = timeout_q;
    illegal      = illegal_q;
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer with a behavioural turn model and a toy GameState.
module tb_move_sequencer;

  localparam int TS   = 3;
  localparam int AUTO = 1;
  localparam int MB = 0, MT = 1, MC = 2, MS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick, btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic [80:0] X_state, O_state;
  logic        move, phase, player, timeout, illegal;
  logic [3:0]  currBoard, currTile, cursor_board, cursor_tile;
  logic [6:0]  time_left;
  logic [27:0] dut_vec;

  move_sequencer #(.TURN_SECONDS(TS), .AUTO_MOVE(AUTO)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_sel(btn_sel), .X_state(X_state), .O_state(O_state),
    .move(move), .currBoard(currBoard), .currTile(currTile),
    .cursor_board(cursor_board), .cursor_tile(cursor_tile),
    .phase(phase), .player(player), .time_left(time_left),
    .timeout(timeout), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign dut_vec = {move, currBoard, currTile, cursor_board, cursor_tile,
                    phase, player, time_left, timeout, illegal};

  int checks = 0;
  int failures = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_st, m_cb, m_ct, m_curb, m_curt, m_player, m_time, m_timeout, m_illegal, m_exp;
  int gs_mode = 0;  // 0 normal, 1 game won (clear all), 2 reject, 3 sub-board draw

  function automatic bit occ_at(int b, int t);
    return X_state[b*9+t] | O_state[b*9+t];
  endfunction

  function automatic bit open_b(int b);
    for (int t = 0; t < 9; t++) if (!occ_at(b, t)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit empty_b(int b);
    for (int t = 0; t < 9; t++) if (occ_at(b, t)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int nav(int pos, int d);
    int r, c;
    r = pos / 3;
    c = pos % 3;
    case (d)
      0: r = (r + 2) % 3;
      1: r = (r + 1) % 3;
      2: c = (c + 2) % 3;
      default: c = (c + 1) % 3;
    endcase
    return 3 * r + c;
  endfunction

  function automatic logic [27:0] model_vec();
    return {(m_st == MC), 4'(m_cb), 4'(m_ct), 4'(m_curb), 4'(m_curt),
            (m_st != MB), m_player[0], 7'(m_time), m_timeout[0], m_illegal[0]};
  endfunction

  task automatic model_reset();
    m_st = MB; m_cb = 0; m_ct = 0; m_curb = 4; m_curt = 4;
    m_player = 0; m_time = TS; m_timeout = 0; m_illegal = 0; m_exp = 0;
  endtask

  task automatic model_step();
    int nst, ncb, nct, ncurb, ncurt, nplayer, ntime, ntimeout, nill, nexp, legal, d, ab, at;
    nst = m_st; ncb = m_cb; nct = m_ct; ncurb = m_curb; ncurt = m_curt;
    nplayer = m_player; ntime = m_time; ntimeout = m_timeout;
    nill = 0; nexp = 0; legal = 0; d = -1; ab = -1; at = -1;
    if (AUTO == 0 && m_exp != 0) ntimeout = 1;
    if (m_st == MB || m_st == MT) begin
      if (btn_sel) begin
        if (m_st == MB) begin
          if (open_b(m_curb)) begin nst = MT; ncurt = 4; legal = 1; end
          else nill = 1;
        end else begin
          if (!occ_at(m_curb, m_curt)) begin nst = MC; ncb = m_curb; nct = m_curt; legal = 1; end
          else nill = 1;
        end
      end else begin
        if (btn_up) d = 0;
        else if (btn_down) d = 1;
        else if (btn_left) d = 2;
        else if (btn_right) d = 3;
        if (d >= 0) begin
          if (m_st == MB) ncurb = nav(m_curb, d);
          else ncurt = nav(m_curt, d);
        end
      end
      if (AUTO != 0 && m_time == 0 && legal == 0) begin
        if (m_st == MT) ab = open_b(m_curb) ? m_curb : -1;
        else for (int b = 0; b < 9; b++) if (ab < 0 && open_b(b)) ab = b;
        if (ab >= 0) begin
          for (int t = 0; t < 9; t++) if (at < 0 && !occ_at(ab, t)) at = t;
          nst = MC; ncb = ab; nct = at; ncurb = m_curb; ncurt = m_curt;
        end
      end
      if (tick && m_time > 0) begin ntime = m_time - 1; nexp = (m_time == 1); end
    end else if (m_st == MC) begin
      nst = MS;
    end else begin
      if (X_state == '0 && O_state == '0) begin
        nplayer = 0; nst = MB; ncurb = 4; ncurt = 4; ntime = TS; ntimeout = 0;
      end else if (occ_at(m_cb, m_ct) || empty_b(m_cb)) begin
        nplayer = 1 - m_player; ntime = TS; ntimeout = 0; ncurt = 4;
        if (open_b(m_ct)) begin nst = MT; ncurb = m_ct; end
        else nst = MB;
      end else begin
        nill = 1; nst = MT;
      end
    end
    m_st = nst; m_cb = ncb; m_ct = nct; m_curb = ncurb; m_curt = ncurt;
    m_player = nplayer; m_time = ntime; m_timeout = ntimeout; m_illegal = nill; m_exp = nexp;
  endtask

  // Toy GameState: registers the committed move at the edge after the move strobe.
  task automatic gs_update();
    int idx;
    idx = m_cb * 9 + m_ct;
    case (gs_mode)
      0: if (!(X_state[idx] | O_state[idx])) begin
           if (m_player != 0) X_state[idx] = 1'b1;
           else O_state[idx] = 1'b1;
         end
      1: begin X_state = '0; O_state = '0; end
      3: begin X_state[m_cb*9 +: 9] = '0; O_state[m_cb*9 +: 9] = '0; end
      default: ;
    endcase
    gs_mode = 0;
  endtask

  task automatic step(input bit s, input bit u, input bit dn, input bit l, input bit r, input bit tk);
    int prev;
    @(negedge clk);
    btn_sel = s; btn_up = u; btn_down = dn; btn_left = l; btn_right = r; tick = tk;
    @(posedge clk);
    prev = m_st;
    model_step();
    #1;
    if (prev == MC) gs_update();
    chk_eq("cycle_outputs", dut_vec, model_vec());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] t_before;
    rst = 1'b1;
    {tick, btn_up, btn_down, btn_left, btn_right, btn_sel} = '0;
    X_state = '0; O_state = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_eq("reset_state", dut_vec,
           {1'b0, 4'd0, 4'd0, 4'd4, 4'd4, 1'b0, 1'b0, 7'd3, 1'b0, 1'b0});

    // First move: sel, sel on the centre board/tile.
    step(1, 0, 0, 0, 0, 0);
    chk_eq("sel1_phase", phase, 1);
    step(1, 0, 0, 0, 0, 0);
    chk_eq("commit_move", move, 1);
    chk_eq("commit_board", currBoard, 4);
    chk_eq("commit_tile", currTile, 4);
    step(0, 0, 0, 0, 0, 0);
    chk_eq("settle_move_low", move, 0);
    chk_eq("settle_board_stable", currBoard, 4);
    step(0, 0, 0, 0, 0, 0);
    chk_eq("turn2_player", player, 1);
    chk_eq("turn2_phase", phase, 1);
    chk_eq("turn2_cursor_board", cursor_board, 4);
    chk_eq("turn2_time", time_left, 3);

    // Play tile 0 while board 0 is full: next board is closed.
    X_state[8:0] = 9'h1FF;
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk_eq("nav_to_tile0", cursor_tile, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(2);
    chk_eq("closed_next_phase", phase, 0);
    chk_eq("closed_next_player", player, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk_eq("nav_to_board0", cursor_board, 0);
    step(1, 0, 0, 0, 0, 0);
    chk_eq("closed_sel_illegal", illegal, 1);
    chk_eq("closed_sel_no_move", move, 0);
    chk_eq("closed_sel_phase", phase, 0);
    step(0, 0, 0, 0, 0, 0);
    chk_eq("illegal_one_cycle", illegal, 0);

    // Occupied tile selection.
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    t_before = time_left;
    step(1, 0, 0, 0, 0, 0);
    chk_eq("occupied_illegal", illegal, 1);
    chk_eq("occupied_phase", phase, 1);
    chk_eq("occupied_player", player, 0);
    chk_eq("occupied_time", time_left, t_before);

    // Tile wrap-around.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk_eq("nav_tile2", cursor_tile, 2);
    step(0, 0, 0, 0, 1, 0);
    chk_eq("wrap_right", cursor_tile, 0);
    step(0, 1, 0, 0, 0, 0);
    chk_eq("wrap_up", cursor_tile, 6);

    // Timed auto-move on board 4 with tiles 0-1 taken.
    X_state[37] = 1'b1;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk_eq("timer_zero", time_left, 0);
    step(0, 0, 0, 0, 0, 0);
    chk_eq("auto_move", move, 1);
    chk_eq("auto_board", currBoard, 4);
    chk_eq("auto_tile", currTile, 2);
    idle(2);
    chk_eq("auto_reload", time_left, 3);
    chk_eq("auto_next_board", cursor_board, 2);
    chk_eq("auto_player", player, 1);
    chk_eq("auto_timeout", timeout, 0);

    // Game won: GameState clears everything.
    step(1, 0, 0, 0, 0, 0);
    gs_mode = 1;
    idle(2);
    chk_eq("won_player", player, 0);
    chk_eq("won_phase", phase, 0);
    chk_eq("won_cursor_board", cursor_board, 4);

    // GameState rejects the move.
    X_state[0] = 1'b1;
    O_state[44] = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    gs_mode = 2;
    idle(2);
    chk_eq("reject_illegal", illegal, 1);
    chk_eq("reject_phase", phase, 1);
    chk_eq("reject_player", player, 0);

    // Reset during the move strobe.
    step(1, 0, 0, 0, 0, 0);
    chk_eq("pre_rst_move", move, 1);
    {tick, btn_up, btn_down, btn_left, btn_right, btn_sel} = '0;
    #2 rst = 1'b1;
    #1;
    chk_eq("rst_kills_move", move, 0);
    model_reset();
    X_state = '0; O_state = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_eq("post_rst_state", dut_vec, model_vec());

    // Random play against the model.
    for (int i = 0; i < 4000; i++) begin
      if ((m_st == MB || m_st == MT) && $urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 3))
          0: X_state[$urandom_range(0, 8)*9 +: 9] = 9'h1FF;
          1: X_state[$urandom_range(0, 80)] = 1'b1;
          2: O_state[$urandom_range(0, 80)] = 1'b1;
          default: begin X_state = '0; O_state = '0; end
        endcase
      end
      if (m_st == MC) gs_mode = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
